// File: rtl/product_accumulator_pkg.sv
// product_accumulator_pkg: shared defaults, FSM state encoding and counter-width helper
package product_accumulator_pkg;

    localparam int P_WIDTH_DEF   = 8;
    localparam int ACC_WIDTH_DEF = 12;
    localparam int COUNT_DEF     = 16;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Bits needed to hold values 0..count.
    function automatic int count_w(input int count);
        return $clog2(count + 1);
    endfunction

endpackage

// File: rtl/product_accumulator_if.sv
// product_accumulator_if: input/output valid-ready bus of the product accumulator
//   in_valid/in_ready/in_product : product stream into the accumulator
//   out_valid/out_ready/out_sum/out_overflow : finished block result
//   master = producer/consumer side, slave = accumulator side
interface product_accumulator_if
    import product_accumulator_pkg::*;
#(
    parameter int P_WIDTH   = P_WIDTH_DEF,
    parameter int ACC_WIDTH = ACC_WIDTH_DEF
);
    logic                 in_valid;
    logic                 in_ready;
    logic [P_WIDTH-1:0]   in_product;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] out_sum;
    logic                 out_overflow;

    modport master (
        output in_valid, in_product, out_ready,
        input  in_ready, out_valid, out_sum, out_overflow
    );

    modport slave (
        input  in_valid, in_product, out_ready,
        output in_ready, out_valid, out_sum, out_overflow
    );
endinterface

// File: rtl/product_accumulator.sv
// product_accumulator: sums blocks of COUNT products and presents each block sum on valid/ready
//   clk, rst_n : clock and asynchronous active-low reset
//   clear      : synchronous abort of partial block and held result
//   bus        : product input and result output handshakes (slave modport)
//   busy       : a block is partially accumulated or a result is held
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter int P_WIDTH   = P_WIDTH_DEF,
    parameter int ACC_WIDTH = ACC_WIDTH_DEF,
    parameter int COUNT     = COUNT_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    product_accumulator_if.slave  bus,
    output logic                  busy
);

    localparam int COUNT_W = count_w(COUNT);

    state_t               state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d, sum_q, sum_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic                 ovf_q, ovf_d, out_ovf_q, out_ovf_d, in_ready_q, in_ready_d;
    logic [ACC_WIDTH:0]   add;
    logic                 accept, last;

    always_comb begin
        add        = {1'b0, acc_q} + (ACC_WIDTH + 1)'(bus.in_product);
        accept     = bus.in_valid & in_ready_q & ~clear;
        last       = count_q == COUNT_W'(COUNT - 1);
        state_d    = state_q;
        acc_d      = acc_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        sum_d      = sum_q;
        out_ovf_d  = out_ovf_q;
        if (clear) begin
            state_d = ACCUM;
            acc_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (state_q == HOLD) begin
            if (bus.out_ready) state_d = ACCUM;
        end else if (accept) begin
            if (last) begin
                sum_d     = add[ACC_WIDTH-1:0];
                out_ovf_d = ovf_q | add[ACC_WIDTH];
                acc_d     = '0;
                count_d   = '0;
                ovf_d     = 1'b0;
                state_d   = HOLD;
            end else begin
                acc_d   = add[ACC_WIDTH-1:0];
                ovf_d   = ovf_q | add[ACC_WIDTH];
                count_d = count_q + COUNT_W'(1);
            end
        end
        // Registered from the next state so in_ready never sees in_valid combinationally.
        in_ready_d = state_d == ACCUM;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ACCUM;
            acc_q      <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            sum_q      <= '0;
            out_ovf_q  <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            sum_q      <= sum_d;
            out_ovf_q  <= out_ovf_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.out_valid    = state_q == HOLD;
    assign bus.out_sum      = sum_q;
    assign bus.out_overflow = out_ovf_q;
    assign busy             = (count_q != '0) | (state_q == HOLD);

endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: scoreboard bench for default, ACC_WIDTH=10 and COUNT=1 accumulators
module tb_product_accumulator;

    typedef struct packed {
        logic [11:0] sum;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, clear;
    logic        iv[3], ordy[3], ir[3], ov[3], oo[3], bsy[3];
    logic [7:0]  ip[3];
    logic [11:0] os[3];
    exp_t        sb[3][$];
    int          n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    product_accumulator_if #(.P_WIDTH(8), .ACC_WIDTH(12)) if0 ();
    product_accumulator_if #(.P_WIDTH(8), .ACC_WIDTH(10)) if1 ();
    product_accumulator_if #(.P_WIDTH(8), .ACC_WIDTH(12)) if2 ();

    product_accumulator #(.P_WIDTH(8), .ACC_WIDTH(12), .COUNT(16)) u0 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(if0), .busy(bsy[0]));
    product_accumulator #(.P_WIDTH(8), .ACC_WIDTH(10), .COUNT(16)) u1 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(if1), .busy(bsy[1]));
    product_accumulator #(.P_WIDTH(8), .ACC_WIDTH(12), .COUNT(1)) u2 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(if2), .busy(bsy[2]));

    assign if0.in_valid = iv[0];  assign if0.in_product = ip[0];  assign if0.out_ready = ordy[0];
    assign if1.in_valid = iv[1];  assign if1.in_product = ip[1];  assign if1.out_ready = ordy[1];
    assign if2.in_valid = iv[2];  assign if2.in_product = ip[2];  assign if2.out_ready = ordy[2];
    assign ir[0] = if0.in_ready;  assign ov[0] = if0.out_valid;  assign os[0] = if0.out_sum;          assign oo[0] = if0.out_overflow;
    assign ir[1] = if1.in_ready;  assign ov[1] = if1.out_valid;  assign os[1] = {2'b00, if1.out_sum}; assign oo[1] = if1.out_overflow;
    assign ir[2] = if2.in_ready;  assign ov[2] = if2.out_valid;  assign os[2] = if2.out_sum;          assign oo[2] = if2.out_overflow;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic push(input int k, input int sum, input logic ovf);
        exp_t e;
        e.sum = 12'(sum);
        e.ovf = ovf;
        sb[k].push_back(e);
    endtask

    // Offers one product and returns #1 after the edge that accepted it.
    task automatic send(input int k, input logic [7:0] p);
        int n = 0;
        iv[k] = 1'b1;
        ip[k] = p;
        while (!ir[k] && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n == 50) chk("in_ready wait", ir[k], 1);
        @(posedge clk);
        #1;
        iv[k] = 1'b0;
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            if (ov[k] && ordy[k]) begin
                if (sb[k].size() == 0) chk("unexpected result", ov[k], 0);
                else begin
                    e = sb[k].pop_front();
                    chk($sformatf("out_sum[%0d]", k), os[k], e.sum);
                    chk($sformatf("out_overflow[%0d]", k), oo[k], e.ovf);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b1;
        clear = 1'b0;
        for (int k = 0; k < 3; k++) begin
            iv[k] = 1'b0; ip[k] = '0; ordy[k] = 1'b1;
        end
        #2 rst_n = 1'b0;
        #1;
        chk("reset out_valid", ov[0], 0);
        chk("reset out_sum", os[0], 0);
        chk("reset busy", bsy[0], 0);
        chk("reset in_ready", ir[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("in_ready before first edge", ir[0], 0);
        @(posedge clk);
        #1;
        chk("in_ready after release", ir[0], 1);

        // b=15, a=0..15 -> 15*120 = 1800
        push(0, 1800, 1'b0);
        for (int a = 0; a < 16; a++) send(0, 8'(15 * a));
        @(negedge clk);
        chk("block latency", ov[0], 1);
        @(posedge clk);
        #1;
        chk("in_ready after handshake", ir[0], 1);

        // backpressure: result held 5 cycles
        ordy[0] = 1'b0;
        push(0, 1800, 1'b0);
        for (int a = 0; a < 16; a++) send(0, 8'(15 * a));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("held out_valid", ov[0], 1);
            chk("held out_sum", os[0], 1800);
            chk("held in_ready", ir[0], 0);
        end
        @(posedge clk);
        #1;
        ordy[0] = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        chk("resume in_ready", ir[0], 1);
        chk("resume out_valid", ov[0], 0);

        // reset mid-block
        for (int i = 0; i < 3; i++) send(0, 8'd50);
        chk("busy mid-block", bsy[0], 1);
        rst_n = 1'b0;
        #1;
        chk("mid reset out_valid", ov[0], 0);
        chk("mid reset out_sum", os[0], 0);
        chk("mid reset busy", bsy[0], 0);
        chk("mid reset in_ready", ir[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready after mid reset", ir[0], 1);

        // overflow with ACC_WIDTH=10: 16*225 = 3600 mod 1024 = 528
        push(1, 528, 1'b1);
        for (int i = 0; i < 16; i++) send(1, 8'd225);
        @(negedge clk);
        chk("overflow latency", ov[1], 1);
        push(1, 0, 1'b0);
        for (int i = 0; i < 16; i++) send(1, 8'd0);
        @(negedge clk);

        // clear drops the partial block and the coinciding product
        for (int i = 0; i < 7; i++) send(0, 8'd9);
        chk("busy before clear", bsy[0], 1);
        iv[0] = 1'b1;
        ip[0] = 8'd9;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        iv[0] = 1'b0;
        chk("busy after clear", bsy[0], 0);
        chk("in_ready after clear", ir[0], 1);
        push(0, 16, 1'b0);
        for (int i = 0; i < 16; i++) send(0, 8'd1);
        @(negedge clk);
        chk("post-clear latency", ov[0], 1);

        // COUNT=1 with gaps
        push(2, 200, 1'b0);
        send(2, 8'd200);
        @(negedge clk);
        chk("count1 first latency", ov[2], 1);
        repeat (3) @(posedge clk);
        #1;
        push(2, 55, 1'b0);
        send(2, 8'd55);
        @(negedge clk);
        chk("count1 second latency", ov[2], 1);

        repeat (5) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) chk($sformatf("pending results[%0d]", k), sb[k].size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Downstream consumer of the 4x4 shift-and-add multiplier's 8-bit product `p`.
- Sums a fixed-length block of COUNT products into a wider accumulator.
- Presents each finished block sum on a valid/ready output handshake.
- Input side is also valid/ready, so a sequencer can stall the multiplier operand stream.

Parameters:
P_WIDTH, 8, width of incoming product (matches multiplier `p`)
ACC_WIDTH, 12, accumulator/result width; sum wraps modulo 2^ACC_WIDTH
COUNT, 16, products per block; legal range 1..2^16-1

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous, active-low reset
clear  input  1  synchronous abort: discard partial block and any held result
in_valid  input  1  in_product is valid this cycle
in_ready  output  1  block accepts a product this cycle
in_product  input  P_WIDTH  unsigned product from multiplier
out_valid  output  1  out_sum/out_overflow hold a finished block
out_ready  input  1  downstream accepts result
out_sum  output  ACC_WIDTH  block sum modulo 2^ACC_WIDTH
out_overflow  output  1  a carry out of ACC_WIDTH occurred during this block
busy  output  1  at least one product of the current block is accepted, or a result is held

Behaviour:
- Interface (already decided): one clock `clk`; reset `rst_n` is asynchronous and active-low.
- On rst_n low, immediately:
  - state = ACCUM; acc = 0; count = 0; ovf = 0.
  - Outputs: out_valid = 0, out_sum = 0, out_overflow = 0, in_ready = 0, busy = 0.
- Release: in_ready rises on the first clk edge after rst_n deasserts. in_ready is a registered, state-derived signal and never depends combinationally on in_valid.
- FSM states: ACCUM, HOLD.
- ACCUM:
  - in_ready = 1, out_valid = 0.
  - Accept = in_valid & in_ready. On accept: acc <= acc + zero-extended in_product; ovf <= ovf | carry; count <= count + 1.
  - On accept when count == COUNT-1:
    - out_sum <= acc + in_product; out_overflow <= ovf | carry.
    - acc <= 0; count <= 0; ovf <= 0; state <= HOLD.
  - Latency: out_valid is asserted the cycle after the last product is accepted.
- HOLD:
  - in_ready = 0, out_valid = 1; out_sum and out_overflow are stable.
  - On out_valid & out_ready: state <= ACCUM; in_ready = 1 the next cycle. Throughput is one result per COUNT+1 cycles minimum.
  - out_valid must not drop without a handshake, except on clear or reset.
- clear:
  - Highest priority after reset; takes effect on any edge where it is sampled high.
  - Sets state = ACCUM, acc = 0, count = 0, ovf = 0, out_valid = 0. out_sum keeps its value.
  - An in_valid coinciding with clear is not accepted (its product is dropped); any held result is dropped.
- COUNT = 1: every accepted product goes directly to HOLD with out_sum = in_product.
- Wrap-around: sums exceeding 2^ACC_WIDTH-1 wrap; out_overflow is sticky per block and reset per block.
- Defaults: COUNT*(2^P_WIDTH-1) fits in ACC_WIDTH for operands ≤15×15 (max 3600 < 4096).
- busy = (count != 0) | (state == HOLD).
- Reset mid-block: the partial sum is lost; no result is emitted.

Decomposition:
- Shared package: P_WIDTH and ACC_WIDTH defaults, COUNT_W = clog2(COUNT+1) helper, state encoding constants (ACCUM = 1'b0, HOLD = 1'b1).
- No sub-module. Counter, adder and FSM are small enough to live in one module.

Test Plan:
- Reset/idle: assert rst_n low mid-simulation → out_valid, out_sum, busy and in_ready all 0 within the same cycle; in_ready = 1 the first edge after release.
- Block sum: b=15, a=0..15 through the multiplier, in_valid held high, out_ready=1 → out_valid one cycle after the 16th accept, out_sum = 1800, out_overflow = 0.
- Backpressure: same stream with out_ready=0 for 5 cycles after out_valid → out_sum stable at 1800, in_ready = 0 throughout; accepting resumes the cycle after the handshake.
- Overflow: ACC_WIDTH=10 override, sixteen products of 225 → out_sum = 3600 mod 1024 = 528, out_overflow = 1; the next block of zeros gives out_sum = 0, out_overflow = 0.
- Clear: after 7 products of 9, pulse clear together with in_valid → busy = 0, that product is dropped; a following 16 × 1 block gives out_sum = 16.
- COUNT=1 with gaps: COUNT=1 override, products 200 then 55 with in_valid gaps → two results, 200 then 55, each one cycle after its accept.
